// File: rtl/secuenciador_ejes.sv
// Two-axis step/dir sequencer: grants one shared driver to teta (priority) or fi.
// Optional limit-switch homing is enabled by defining SECUENCIADOR_HOME_EN.
module secuenciador_ejes #(
  parameter int STEP_DIV   = 1000,
  parameter int SETTLE_CYC = 256,
  parameter int MAX_STEPS  = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] req_teta,
  input  logic [1:0] req_fi,
`ifdef SECUENCIADOR_HOME_EN
  input  logic       home_teta,
  input  logic       home_fi,
`endif
  output logic       step,
  output logic       dir,
  output logic       axis_sel,
  output logic       busy,
  output logic [8:0] pos_teta,
  output logic [8:0] pos_fi,
  output logic       fault
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int NST_W = $clog2(MAX_STEPS + 1);
  localparam logic [8:0] POS_MAX = 9'd359;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [SET_W-1:0] settle_cnt;
  logic [NST_W-1:0] nsteps;

  logic       teta_valid;
  logic       fi_valid;
  logic [1:0] req_sel;
  logic       same_dir;
  logic       period_end;
  logic       step_now;
  logic       home_hit;

  assign teta_valid = ^req_teta;
  assign fi_valid   = ^req_fi;
  assign req_sel    = axis_sel ? req_fi : req_teta;
  // A request keeps the move going only if it matches the direction already granted.
  assign same_dir   = (req_sel == {dir, ~dir});
  assign period_end = (cnt == CNT_W'(STEP_DIV - 1));
  assign step_now   = (state == S_RUN) && (cnt == '0);

`ifdef SECUENCIADOR_HOME_EN
  assign home_hit = ~dir & (axis_sel ? home_fi : home_teta);
`else
  assign home_hit = 1'b0;
`endif

  assign step  = step_now;
  assign busy  = (state == S_RUN) || (state == S_SETTLE);
  assign fault = (state == S_FAULT);

  function automatic logic [8:0] pos_step(input logic [8:0] p, input logic up);
    if (up)
      return (p == POS_MAX) ? 9'd0 : p + 9'd1;
    else
      return (p == 9'd0) ? POS_MAX : p - 9'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      settle_cnt <= '0;
      nsteps     <= '0;
      dir        <= 1'b0;
      axis_sel   <= 1'b0;
      pos_teta   <= '0;
      pos_fi     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
`ifdef SECUENCIADOR_HOME_EN
          if (home_teta) pos_teta <= '0;
          if (home_fi)   pos_fi   <= '0;
`endif
          if (enable && (teta_valid || fi_valid)) begin
            state    <= S_RUN;
            cnt      <= '0;
            nsteps   <= '0;
            axis_sel <= ~teta_valid;
            dir      <= teta_valid ? req_teta[1] : req_fi[1];
          end
        end

        S_RUN: begin
          // A step already high always lands, even if enable drops on this edge.
          if (step_now) begin
            if (!axis_sel)
              pos_teta <= home_hit ? 9'd0 : pos_step(pos_teta, dir);
            else
              pos_fi   <= home_hit ? 9'd0 : pos_step(pos_fi, dir);
            nsteps <= nsteps + NST_W'(1);
          end
          cnt <= period_end ? '0 : cnt + CNT_W'(1);
          if (!enable) begin
            state <= S_IDLE;
          end else if (step_now && home_hit) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
          end else if (period_end) begin
            if (nsteps >= NST_W'(MAX_STEPS)) begin
              state <= S_FAULT;
            end else if (!same_dir) begin
              state      <= S_SETTLE;
              settle_cnt <= '0;
            end
          end
        end

        S_SETTLE: begin
          if (!enable || (settle_cnt == SET_W'(SETTLE_CYC - 1)))
            state <= S_IDLE;
          else
            settle_cnt <= settle_cnt + SET_W'(1);
        end

        S_FAULT: begin
          if (!enable) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/secuenciador_ejes.md
Name: secuenciador_ejes

Overview:
- Motion sequencer for the two-axis tracker. Shares one stepper driver (step/dir) between the vertical axis (teta) and the horizontal axis (fi).
- Consumes the 2-bit per-axis direction requests produced by the automatic/manual comparator logic and grants the driver to one axis at a time. Teta has priority, so fi moves only once teta is settled.
- Generates paced step pulses, a settle gap between moves, per-axis 0..359 position counters, and a runaway-move fault.

Parameters:
- STEP_DIV, 1000, clock cycles per step period (>=2).
- SETTLE_CYC, 256, idle cycles after every move before the next grant (>=1).
- MAX_STEPS, 4095, steps allowed in one continuous move before fault (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  sequencer enable; low forces IDLE
- req_teta  in  2  teta request: 01 = decrease angle, 10 = increase, 00/11 = no move
- req_fi  in  2  fi request, same encoding
- step  out  1  one-cycle step pulse to driver
- dir  out  1  1 = increase angle, 0 = decrease
- axis_sel  out  1  0 = teta owns driver, 1 = fi
- busy  out  1  high in RUN or SETTLE
- pos_teta  out  9  teta position, 0..359
- pos_fi  out  9  fi position, 0..359
- fault  out  1  move exceeded MAX_STEPS

Behaviour:
Reset:
- rst at any clock edge, including mid-move, on the same edge: state=IDLE; step, dir, axis_sel, busy, fault, pos_teta, pos_fi all 0; step and settle counters cleared.

States: IDLE, RUN, SETTLE, FAULT.

IDLE:
- Requests are evaluated every cycle while enable=1.
- Valid req_teta (01/10) wins: axis_sel=0, dir=req_teta[1]. Otherwise a valid req_fi: axis_sel=1, dir=req_fi[1]. Both valid: teta.
- On a grant: go to RUN, clear step counter cnt and move count nsteps.
- Grant decided at edge k -> step=1 during cycle k..k+1, i.e. the first RUN cycle. Latency 1 clock from request to first step.

RUN:
- cnt counts 0..STEP_DIV-1 and wraps. step=1 exactly in cycles where cnt==0, else 0. Step frequency = clk/STEP_DIV.
- On the edge ending a step-high cycle:
  - Granted-axis position moves by ±1 with wrap: dir=1 gives 359->0; dir=0 gives 0->359. The other axis is unchanged.
  - nsteps increments.
- At cnt==STEP_DIV-1, resample the granted axis request:
  - Same direction: continue.
  - 00/11 or opposite direction: go to SETTLE. No direct reversal.
  - Priority is not re-arbitrated mid-move: a teta request arriving while fi moves waits for SETTLE end.
- If nsteps reaches MAX_STEPS: go to FAULT at that period end, regardless of request.
- axis_sel and dir are held constant throughout RUN.

SETTLE:
- step=0. Count SETTLE_CYC cycles, then go to IDLE. busy=1.

FAULT:
- step=0, busy=0, fault=1. Positions are frozen.
- Exit only when enable=0 (or rst), which clears fault and returns to IDLE.

enable=0 in RUN or SETTLE:
- Next edge goes to IDLE, step=0. A step-high cycle already in progress completes its position update; no partial steps.

Arithmetic:
- Positions are 9-bit unsigned. Increment uses compare-to-359, not modulo.
- nsteps width is clog2(MAX_STEPS+1).

Optional Feature:
SECUENCIADOR_HOME_EN
- Defined:
  - Adds inputs home_teta and home_fi (1 bit each, active-high limit switches, already synchronised).
  - In RUN with dir=0 on the matching axis, home asserted at the next step-high edge: that axis position loads 0 instead of decrementing, and the state goes to SETTLE.
  - In IDLE, home asserted loads that position to 0.
- Undefined: ports absent; positions change only by stepping.

Test Plan:
Test parameters: STEP_DIV=4, SETTLE_CYC=3, MAX_STEPS=5.
1. rst, then req_teta=10 held for 3 periods, then 00 -> step pulses at RUN cycles 0, 4, 8; pos_teta=3; busy drops 3 cycles after RUN exit; pos_fi=0.
2. req_teta=10 and req_fi=01 asserted together -> axis_sel=0 first. After teta drops and SETTLE completes, axis_sel=1 with dir=0; pos_fi goes 0 -> 359 on the first fi step.
3. pos_teta=358 with req_teta=10 for 3 steps -> pos_teta sequence 359, 0, 1.
4. req_fi=10 held forever -> after 5 steps, fault=1 and step stays 0. Then enable=0 for 1 cycle -> fault=0, state IDLE.
5. req_teta flips 10->01 mid-move -> enters SETTLE (3 cycles, no steps), then a new RUN with dir=0.
6. rst asserted during a step-high cycle -> next edge: step=0, positions=0, busy=0.
